// File: rtl/rvv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvv_pkg
// Description : Shared vector-configuration types. Holds the SEW and LMUL
//               encodings, the legality check for a (sew, lmul) pair and
//               the default vector register length.
// Revision    : 1.0 - initial release
// ============================================================================
package rvv_pkg;

    localparam int c_default_vlen = 64;

    // Element width encodings; 3'b101..3'b111 are reserved.
    typedef enum logic [2:0] {
        SEW_4  = 3'b000,
        SEW_8  = 3'b001,
        SEW_16 = 3'b010,
        SEW_32 = 3'b011,
        SEW_64 = 3'b100
    } sew_e;

    // Register-group multiplier encodings; 3'b101..3'b111 are reserved.
    typedef enum logic [2:0] {
        LMUL_1  = 3'b000,
        LMUL_2  = 3'b001,
        LMUL_4  = 3'b010,
        LMUL_8  = 3'b011,
        LMUL_16 = 3'b100
    } lmul_e;

    function automatic logic is_legal(input logic [2:0] sew, input logic [2:0] lmul);
        return (sew <= 3'b100) && (lmul <= 3'b100);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vlmax_calc.sv
`default_nettype none
// ============================================================================
// Module      : vlmax_calc
// Description : Combinational VLMAX = VLEN / SEW * LMUL, saturated to the
//               largest value representable in AVL_W bits. Illegal
//               encodings report legal=0 and VLMAX=0.
// Ports       : i_sew    - encoded element width
//               i_lmul   - encoded register-group multiplier
//               o_vlmax  - saturated VLMAX (0 when illegal)
//               o_legal  - 1 when both encodings are legal
// Revision    : 1.0 - initial release
// ============================================================================
module vlmax_calc
    import rvv_pkg::*;
#(
    parameter int VLEN  = c_default_vlen,
    parameter int AVL_W = 9
) (
    input  sew_e               i_sew,
    input  lmul_e              i_lmul,
    output logic [AVL_W-1:0]   o_vlmax,
    output logic               o_legal
);

    // 32-bit working width: 4*VLEN always fits for any practical VLEN.
    localparam logic [31:0] c_sat = (32'd1 << AVL_W) - 32'd1;

    logic [31:0] w_base;
    logic [31:0] w_full;

    always_comb begin
        o_legal = is_legal(i_sew, i_lmul);
        // SEW = 4 << sew, so VLEN/SEW = VLEN >> (sew + 2).
        w_base  = 32'(VLEN) >> (32'(i_sew) + 32'd2);
        w_full  = w_base << 32'(i_lmul);
        if (!o_legal) begin
            o_vlmax = '0;
        end else if (w_full > c_sat) begin
            o_vlmax = c_sat[AVL_W-1:0];
        end else begin
            o_vlmax = w_full[AVL_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/vl_strip_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vl_strip_ctrl
// Description : Accepts one vsetvl-style request (SEW, LMUL, AVL) and
//               strip-mines AVL into successive vl values, one per strip,
//               with valid/ready handshakes on both sides, abort and a
//               wrapping strip index.
// Ports       : clk, rst                 - clock, async active-high reset
//               cfg_valid/cfg_ready      - request handshake (ready in IDLE)
//               cfg_sew/cfg_lmul/cfg_avl - request payload
//               abort                    - cancel the strip sequence
//               vl_valid/vl_ready        - strip handshake
//               vl, vl_last, strip_idx   - current strip
//               vlmax, vill              - latched per-request results
//               done, aborted            - end-of-request pulse and cause
// Revision    : 1.0 - initial release
// ============================================================================
module vl_strip_ctrl
    import rvv_pkg::*;
#(
    parameter int VLEN  = c_default_vlen,
    parameter int AVL_W = 9,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_sew,
    input  logic [2:0]       cfg_lmul,
    input  logic [AVL_W-1:0] cfg_avl,
    input  logic             abort,
    output logic             vl_valid,
    input  logic             vl_ready,
    output logic [AVL_W-1:0] vl,
    output logic             vl_last,
    output logic [IDX_W-1:0] strip_idx,
    output logic [AVL_W-1:0] vlmax,
    output logic             vill,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STRIP = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_accept;
    logic             w_take;

    logic [AVL_W-1:0] r_rem;
    logic [AVL_W-1:0] r_vl;
    logic             r_last;
    logic [IDX_W-1:0] r_idx;
    logic [AVL_W-1:0] r_vlmax;
    logic             r_vill;
    logic             r_done;
    logic             r_aborted;

    logic [AVL_W-1:0] w_calc_vlmax;
    logic             w_legal;
    logic [AVL_W-1:0] w_rem_step;
    logic [AVL_W-1:0] w_min_a;
    logic [AVL_W-1:0] w_min_b;
    logic             w_fits;
    logic [AVL_W-1:0] w_min;

    vlmax_calc #(
        .VLEN  (VLEN),
        .AVL_W (AVL_W)
    ) u_vlmax_calc (
        .i_sew   (sew_e'(cfg_sew)),
        .i_lmul  (lmul_e'(cfg_lmul)),
        .o_vlmax (w_calc_vlmax),
        .o_legal (w_legal)
    );

    // One min comparator serves both the first strip (AVL vs fresh VLMAX)
    // and every following strip (remaining count vs latched VLMAX).
    assign w_rem_step = r_rem - r_vl;
    assign w_min_a    = (r_state == ST_IDLE) ? cfg_avl      : w_rem_step;
    assign w_min_b    = (r_state == ST_IDLE) ? w_calc_vlmax : r_vlmax;
    assign w_fits     = (w_min_a <= w_min_b);
    assign w_min      = w_fits ? w_min_a : w_min_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_take       = 1'b0;
        cfg_ready    = (r_state == ST_IDLE);
        vl_valid     = (r_state == ST_STRIP);
        case (r_state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    w_accept = 1'b1;
                    if (w_legal && (cfg_avl != '0)) begin
                        w_state_next = ST_STRIP;
                    end
                end
            end
            ST_STRIP: begin
                // Abort wins: a strip handshaken in the same cycle is not taken.
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (vl_ready) begin
                    w_take = 1'b1;
                    if (r_last) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem     <= '0;
            r_vl      <= '0;
            r_last    <= 1'b0;
            r_idx     <= '0;
            r_vlmax   <= '0;
            r_vill    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (w_accept) begin
                r_vill  <= ~w_legal;
                r_vlmax <= w_calc_vlmax;
                if (!w_legal || (cfg_avl == '0)) begin
                    r_done <= 1'b1;
                end else begin
                    r_rem  <= cfg_avl;
                    r_vl   <= w_min;
                    r_last <= w_fits;
                    r_idx  <= '0;
                end
            end else if ((r_state == ST_STRIP) && abort) begin
                r_done    <= 1'b1;
                r_aborted <= 1'b1;
            end else if (w_take) begin
                r_rem <= w_rem_step;
                if (r_last) begin
                    r_done <= 1'b1;
                end else begin
                    r_vl   <= w_min;
                    r_last <= w_fits;
                    r_idx  <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign vl        = r_vl;
    assign vl_last   = r_last;
    assign strip_idx = r_idx;
    assign vlmax     = r_vlmax;
    assign vill      = r_vill;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_vl_strip_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vl_strip_ctrl
// Description : Self-checking bench for vl_strip_ctrl (VLEN=64, AVL_W=9).
//               Expected strips come from a reference model that divides
//               AVL into VLMAX-sized chunks using plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vl_strip_ctrl;

    localparam int c_vlen  = 64;
    localparam int c_avl_w = 9;
    localparam int c_idx_w = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [2:0]           cfg_sew = '0;
    logic [2:0]           cfg_lmul = '0;
    logic [c_avl_w-1:0]   cfg_avl = '0;
    logic                 abort = 1'b0;
    logic                 vl_valid;
    logic                 vl_ready = 1'b0;
    logic [c_avl_w-1:0]   vl;
    logic                 vl_last;
    logic [c_idx_w-1:0]   strip_idx;
    logic [c_avl_w-1:0]   vlmax;
    logic                 vill;
    logic                 done;
    logic                 aborted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vl_strip_ctrl #(
        .VLEN  (c_vlen),
        .AVL_W (c_avl_w),
        .IDX_W (c_idx_w)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sew   (cfg_sew),
        .cfg_lmul  (cfg_lmul),
        .cfg_avl   (cfg_avl),
        .abort     (abort),
        .vl_valid  (vl_valid),
        .vl_ready  (vl_ready),
        .vl        (vl),
        .vl_last   (vl_last),
        .strip_idx (strip_idx),
        .vlmax     (vlmax),
        .vill      (vill),
        .done      (done),
        .aborted   (aborted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference VLMAX: elements per register times register-group size.
    function automatic int model_vlmax(input int sew, input int lmul);
        int v;
        if (sew > 4 || lmul > 4) return 0;
        v = (c_vlen * (1 << lmul)) / (4 << sew);
        if (v > 511) v = 511;
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_vl_valid"}, 32'(vl_valid), 0);
        chk({tag, "_vl"}, 32'(vl), 0);
        chk({tag, "_vl_last"}, 32'(vl_last), 0);
        chk({tag, "_strip_idx"}, 32'(strip_idx), 0);
        chk({tag, "_vlmax"}, 32'(vlmax), 0);
        chk({tag, "_vill"}, 32'(vill), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_aborted"}, 32'(aborted), 0);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
    endtask

    // One full request. pct: vl_ready probability; stall_k/stall_n: hold
    // vl_ready low stall_n cycles on strip stall_k; abort_k: strip on which
    // abort is raised together with vl_ready (-1 = never).
    task automatic run_req(input int sew, input int lmul, input int avl, input int pct,
                           input int stall_k, input int stall_n, input int abort_k);
        int  exp_vlmax;
        int  rem;
        int  k;
        int  cyc;
        int  stalled;
        int  exp_vl;
        bit  exp_last;
        bit  legal;
        bit  fin;
        bit  rdy;
        legal     = (sew <= 4) && (lmul <= 4);
        exp_vlmax = model_vlmax(sew, lmul);

        @(negedge clk);
        chk("cfg_ready_idle", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_sew   = sew[2:0];
        cfg_lmul  = lmul[2:0];
        cfg_avl   = avl[c_avl_w-1:0];
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("vill", 32'(vill), 32'(!legal));
        chk("vlmax", 32'(vlmax), exp_vlmax);

        if (!legal || avl == 0) begin
            chk("done_nostrip", 32'(done), 1);
            chk("aborted_nostrip", 32'(aborted), 0);
            chk("no_strip_valid", 32'(vl_valid), 0);
            @(negedge clk);
            chk("done_pulse_nostrip", 32'(done), 0);
            chk("no_strip_valid2", 32'(vl_valid), 0);
            return;
        end

        chk("done_early", 32'(done), 0);
        rem = avl; k = 0; cyc = 0; stalled = 0; fin = 1'b0;
        while (!fin && cyc < 2000) begin
            exp_vl   = (rem < exp_vlmax) ? rem : exp_vlmax;
            exp_last = (rem <= exp_vlmax);
            chk("vl_valid", 32'(vl_valid), 1);
            chk("vl", 32'(vl), exp_vl);
            chk("vl_last", 32'(vl_last), 32'(exp_last));
            chk("strip_idx", 32'(strip_idx), k % 256);
            chk("cfg_ready_busy", 32'(cfg_ready), 0);
            if (k == abort_k) begin
                vl_ready = 1'b1;
                abort    = 1'b1;
                @(negedge clk);
                vl_ready = 1'b0;
                abort    = 1'b0;
                chk("abort_done", 32'(done), 1);
                chk("abort_aborted", 32'(aborted), 1);
                chk("abort_vl_valid", 32'(vl_valid), 0);
                chk("abort_cfg_ready", 32'(cfg_ready), 1);
                fin = 1'b1;
                @(negedge clk);
                chk("abort_done_pulse", 32'(done), 0);
                chk("abort_aborted_pulse", 32'(aborted), 0);
            end else begin
                if (k == stall_k && stalled < stall_n) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = ($urandom_range(99) < pct);
                end
                vl_ready = rdy;
                @(negedge clk);
                vl_ready = 1'b0;
                if (rdy) begin
                    rem -= exp_vl;
                    k++;
                    if (exp_last) begin
                        chk("end_done", 32'(done), 1);
                        chk("end_aborted", 32'(aborted), 0);
                        chk("end_vl_valid", 32'(vl_valid), 0);
                        chk("end_cfg_ready", 32'(cfg_ready), 1);
                        chk("end_rem_zero", 32'(rem), 0);
                        fin = 1'b1;
                        @(negedge clk);
                        chk("end_done_pulse", 32'(done), 0);
                    end else begin
                        chk("mid_done", 32'(done), 0);
                    end
                end else begin
                    chk("stall_done", 32'(done), 0);
                end
            end
            cyc++;
        end
        if (!fin) begin
            total++;
            bad++;
            $error("FAIL timeout: observed=%0d strips expected=request completion", k);
        end
    endtask

    initial begin
        // Reset state.
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_req(1, 0, 20, 100, -1, 0, -1);    // 8,8,4
        run_req(0, 4, 300, 100, -1, 0, -1);   // 256,44
        run_req(4, 0, 3, 100, -1, 0, -1);     // 1,1,1
        run_req(1, 0, 0, 100, -1, 0, -1);     // empty
        run_req(5, 0, 20, 100, -1, 0, -1);    // illegal sew
        run_req(0, 6, 20, 100, -1, 0, -1);    // illegal lmul
        run_req(1, 0, 20, 100, 1, 5, -1);     // backpressure on strip 1
        run_req(1, 0, 20, 100, -1, 0, 1);     // abort on strip 1
        run_req(4, 0, 300, 100, -1, 0, -1);   // 300 strips, idx wraps past 255

        // Mid-strip asynchronous reset.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_sew = 3'd1; cfg_lmul = 3'd0; cfg_avl = 9'd20;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("pre_rst_vl_valid", 32'(vl_valid), 1);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        #1 rst = 1'b0;
        run_req(1, 0, 20, 100, -1, 0, -1);

        // Randomized requests.
        for (int i = 0; i < 12; i++) begin
            run_req(int'($urandom_range(5)), int'($urandom_range(5)), int'($urandom_range(511)),
                    60, int'($urandom_range(3)), int'($urandom_range(4)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(4)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
